// File: rtl/store_rmw_unit_pkg.sv
// Shared definitions for the store read-modify-write path:
// op encodings, FSM states and the misalignment rule.
package store_rmw_unit_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        OP_SW  = 2'b00,
        OP_SH  = 2'b01,
        OP_SB  = 2'b10,
        OP_RSV = 2'b11
    } op_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_WAIT,
        S_WRITE,
        S_DONE,
        S_ERR
    } state_e;

    // Also used by the control unit to raise store-misaligned exceptions.
    function automatic logic misaligned(op_e op, logic [1:0] lo);
        logic r;
        r = 1'b1;
        case (op)
            OP_SW:   r = (lo != 2'b00);
            OP_SH:   r = lo[0];
            OP_SB:   r = 1'b0;
            default: r = 1'b1;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/store_rmw_unit_if.sv
// Request/memory bundle of the store unit. The master side holds the
// control FSM and the word memory; the slave side is the store unit.
interface store_rmw_unit_if;
    import store_rmw_unit_pkg::*;

    logic            start;
    op_e             op;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] mem_dout;
    logic [XLEN-1:0] mem_addr;
    logic            mem_wr;
    logic [XLEN-1:0] mem_din;
    logic            busy;
    logic            done;
    logic            err;

    modport master (
        output start, op, addr, wdata, mem_dout,
        input  mem_addr, mem_wr, mem_din, busy, done, err
    );

    modport slave (
        input  start, op, addr, wdata, mem_dout,
        output mem_addr, mem_wr, mem_din, busy, done, err
    );

endinterface

// File: rtl/store_rmw_unit_merge.sv
// Merges store data into the old memory word; little-endian lanes.
module store_merge
    import store_rmw_unit_pkg::*;
(
    input  logic [XLEN-1:0] old_word,
    input  logic [XLEN-1:0] wdata,
    input  op_e             op,
    input  logic [1:0]      addr,
    output logic [XLEN-1:0] merged_word
);

    always_comb begin
        merged_word = old_word;
        case (op)
            OP_SW: merged_word = wdata;
            OP_SH: begin
                if (addr[1]) merged_word[31:16] = wdata[15:0];
                else         merged_word[15:0]  = wdata[15:0];
            end
            OP_SB: merged_word[{addr, 3'b000} +: 8] = wdata[7:0];
            default: merged_word = old_word;
        endcase
    end

endmodule

// File: rtl/store_rmw_unit.sv
// Multicycle store unit: sw writes directly, sh/sb read the containing
// word, merge the new lane and write it back.
module store_rmw_unit
    import store_rmw_unit_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    store_rmw_unit_if.slave bus
);

    state_e          r_state;
    state_e          w_next;
    op_e             r_op;
    logic [XLEN-1:0] r_addr;
    logic [XLEN-1:0] r_wdata;
    logic [XLEN-1:0] r_word;
    logic [XLEN-1:0] w_merged;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_op    <= OP_SW;
            r_addr  <= '0;
            r_wdata <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_IDLE && bus.start) begin
                r_op    <= bus.op;
                r_addr  <= bus.addr;
                r_wdata <= bus.wdata;
            end
            if (r_state == S_WAIT) r_word <= bus.mem_dout;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    if (misaligned(bus.op, bus.addr[1:0])) w_next = S_ERR;
                    else if (bus.op == OP_SW)              w_next = S_WRITE;
                    else                                   w_next = S_READ;
                end
            end
            S_READ:  w_next = S_WAIT;
            S_WAIT:  w_next = S_WRITE;
            S_WRITE: w_next = S_DONE;
            S_DONE:  w_next = S_IDLE;
            S_ERR:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    store_merge u_merge (
        .old_word    (r_word),
        .wdata       (r_wdata),
        .op          (r_op),
        .addr        (r_addr[1:0]),
        .merged_word (w_merged)
    );

    // Everything below depends only on registered state.
    assign bus.mem_addr = {r_addr[31:2], 2'b00};
    assign bus.mem_wr   = (r_state == S_WRITE);
    assign bus.mem_din  = w_merged;
    assign bus.busy     = (r_state != S_IDLE);
    assign bus.done     = (r_state == S_DONE) || (r_state == S_ERR);
    assign bus.err      = (r_state == S_ERR);

endmodule

// File: tb/tb_store_rmw_unit.sv
// Directed bench for store_rmw_unit with a 1-cycle-latency word memory.
module tb_store_rmw_unit;
    import store_rmw_unit_pkg::*;

    logic clk;
    logic reset;
    int   n_checks;
    int   n_fail;
    int   wr_cnt;
    logic [31:0] last_wa;
    logic [31:0] last_wd;
    logic [31:0] mem [0:63];

    store_rmw_unit_if bus ();

    store_rmw_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        bus.mem_dout <= mem[bus.mem_addr[7:2]];
        if (bus.mem_wr) begin
            mem[bus.mem_addr[7:2]] <= bus.mem_din;
            wr_cnt  = wr_cnt + 1;
            last_wa = bus.mem_addr;
            last_wd = bus.mem_din;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic launch(input op_e op, input logic [31:0] a,
                          input logic [31:0] d);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = op;
        bus.addr  = a;
        bus.wdata = d;
        step();
        bus.start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step();
        step();
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.mem_wr} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags got %b want 0000",
                     {bus.busy, bus.done, bus.err, bus.mem_wr});
        end
        n_checks++;
        if ({bus.mem_addr, bus.mem_din} !== 64'h0) begin
            n_fail++;
            $display("FAIL reset_bus got %h/%h want 0/0",
                     bus.mem_addr, bus.mem_din);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
    endtask

    task automatic test_sw();
        int w0;
        w0 = wr_cnt;
        launch(OP_SW, 32'h10, 32'hDEAD_BEEF);
        n_checks++;
        if ({bus.mem_wr, bus.busy, bus.done} !== 3'b110 ||
            bus.mem_addr !== 32'h10 || bus.mem_din !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_c1 got wr=%b a=%h d=%h want wr=1 a=10 d=deadbeef",
                     bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        step();
        n_checks++;
        if ({bus.done, bus.err, bus.mem_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL sw_c2 got done/err/wr=%b want 100",
                     {bus.done, bus.err, bus.mem_wr});
        end
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || wr_cnt !== w0 + 1 ||
            mem[4] !== 32'hDEAD_BEEF) begin
            n_fail++;
            $display("FAIL sw_end got busy=%b writes=%0d mem=%h want 0 %0d deadbeef",
                     bus.busy, wr_cnt - w0, mem[4], 1);
        end
    endtask

    task automatic test_sb();
        mem[8] = 32'h1122_3344;
        launch(OP_SB, 32'h22, 32'hFFFF_FFAB);
        n_checks++;
        if (bus.mem_wr !== 1'b0 || bus.mem_addr !== 32'h20 ||
            bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL sb_read got wr=%b a=%h want wr=0 a=20",
                     bus.mem_wr, bus.mem_addr);
        end
        step();
        n_checks++;
        if ({bus.mem_wr, bus.done} !== 2'b00) begin
            n_fail++;
            $display("FAIL sb_wait got wr/done=%b want 00",
                     {bus.mem_wr, bus.done});
        end
        step();
        n_checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 32'h20 ||
            bus.mem_din !== 32'h11AB_3344) begin
            n_fail++;
            $display("FAIL sb_write got wr=%b a=%h d=%h want 1 20 11ab3344",
                     bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        step();
        n_checks++;
        if ({bus.done, bus.err, bus.mem_wr} !== 3'b100) begin
            n_fail++;
            $display("FAIL sb_done got done/err/wr=%b want 100",
                     {bus.done, bus.err, bus.mem_wr});
        end
        step();
    endtask

    task automatic test_sh();
        logic [31:0] a_t [2];
        logic [31:0] e_t [2];
        a_t[0] = 32'h32; e_t[0] = 32'h1234_BBBB;
        a_t[1] = 32'h30; e_t[1] = 32'hAAAA_1234;
        for (int i = 0; i < 2; i++) begin
            mem[12] = 32'hAAAA_BBBB;
            launch(OP_SH, a_t[i], 32'h0000_1234);
            step();
            step();
            n_checks++;
            if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 32'h30 ||
                bus.mem_din !== e_t[i]) begin
                n_fail++;
                $display("FAIL sh_write%0d got wr=%b a=%h d=%h want 1 30 %h",
                         i, bus.mem_wr, bus.mem_addr, bus.mem_din, e_t[i]);
            end
            step();
            n_checks++;
            if ({bus.done, bus.err} !== 2'b10) begin
                n_fail++;
                $display("FAIL sh_done%0d got done/err=%b want 10",
                         i, {bus.done, bus.err});
            end
            step();
            n_checks++;
            if (mem[12] !== e_t[i]) begin
                n_fail++;
                $display("FAIL sh_mem%0d got %h want %h", i, mem[12], e_t[i]);
            end
        end
    endtask

    task automatic test_misaligned();
        op_e         o_t [3];
        logic [31:0] a_t [3];
        int          w0;
        o_t[0] = OP_SH;  a_t[0] = 32'h41;
        o_t[1] = OP_SW;  a_t[1] = 32'h42;
        o_t[2] = OP_RSV; a_t[2] = 32'h40;
        for (int i = 0; i < 3; i++) begin
            w0 = wr_cnt;
            launch(o_t[i], a_t[i], 32'h5555_5555);
            n_checks++;
            if ({bus.done, bus.err, bus.mem_wr, bus.busy} !== 4'b1101) begin
                n_fail++;
                $display("FAIL mis%0d_c1 got done/err/wr/busy=%b want 1101",
                         i, {bus.done, bus.err, bus.mem_wr, bus.busy});
            end
            step();
            n_checks++;
            if ({bus.busy, bus.done, bus.err} !== 3'b000 || wr_cnt !== w0) begin
                n_fail++;
                $display("FAIL mis%0d_end got flags=%b writes=%0d want 000 0",
                         i, {bus.busy, bus.done, bus.err}, wr_cnt - w0);
            end
        end
    endtask

    task automatic test_start_busy();
        int w0;
        logic [3:0] seen_bad;
        w0 = wr_cnt;
        seen_bad = '0;
        mem[20] = 32'h0102_0304;
        mem[24] = 32'h0000_0000;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op    = OP_SB;
        bus.addr  = 32'h50;
        bus.wdata = 32'h0000_0099;
        step();
        bus.addr = 32'h60;
        for (int c = 1; c <= 3; c++) begin
            if (bus.mem_addr !== 32'h50) seen_bad[c] = 1'b1;
            step();
        end
        n_checks++;
        if (seen_bad !== 4'b0000 || bus.done !== 1'b1) begin
            n_fail++;
            $display("FAIL busy_addr got bad=%b done=%b want 0000 1",
                     seen_bad, bus.done);
        end
        step();
        n_checks++;
        if (bus.busy !== 1'b0 || wr_cnt !== w0 + 1 || last_wa !== 32'h50 ||
            last_wd !== 32'h0102_0399) begin
            n_fail++;
            $display("FAIL busy_first got busy=%b writes=%0d a=%h d=%h want 0 1 50 01020399",
                     bus.busy, wr_cnt - w0, last_wa, last_wd);
        end
        step();
        bus.start = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1 || bus.mem_addr !== 32'h60 ||
            bus.mem_wr !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_second got busy=%b a=%h wr=%b want 1 60 0",
                     bus.busy, bus.mem_addr, bus.mem_wr);
        end
        step();
        step();
        step();
        step();
        n_checks++;
        if (wr_cnt !== w0 + 2 || last_wa !== 32'h60 ||
            last_wd !== 32'h0000_0099 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL busy_end got writes=%0d a=%h d=%h busy=%b want 2 60 00000099 0",
                     wr_cnt - w0, last_wa, last_wd, bus.busy);
        end
    endtask

    task automatic test_reset_wait();
        int w0;
        w0 = wr_cnt;
        launch(OP_SH, 32'h32, 32'h0000_7777);
        step();
        @(negedge clk);
        reset = 1'b1;
        step();
        n_checks++;
        if ({bus.busy, bus.done, bus.err, bus.mem_wr} !== 4'b0000 ||
            bus.mem_addr !== 32'h0 || bus.mem_din !== 32'h0) begin
            n_fail++;
            $display("FAIL rst_wait got flags=%b a=%h d=%h want 0000 0 0",
                     {bus.busy, bus.done, bus.err, bus.mem_wr},
                     bus.mem_addr, bus.mem_din);
        end
        @(negedge clk);
        reset = 1'b0;
        step();
        step();
        n_checks++;
        if (wr_cnt !== w0 || mem[12] !== 32'hAAAA_1234) begin
            n_fail++;
            $display("FAIL rst_nowrite got writes=%0d mem=%h want 0 aaaa1234",
                     wr_cnt - w0, mem[12]);
        end
        launch(OP_SW, 32'h70, 32'hCAFE_F00D);
        n_checks++;
        if (bus.mem_wr !== 1'b1 || bus.mem_addr !== 32'h70 ||
            bus.mem_din !== 32'hCAFE_F00D) begin
            n_fail++;
            $display("FAIL rst_sw_c1 got wr=%b a=%h d=%h want 1 70 cafef00d",
                     bus.mem_wr, bus.mem_addr, bus.mem_din);
        end
        step();
        n_checks++;
        if ({bus.done, bus.err} !== 2'b10) begin
            n_fail++;
            $display("FAIL rst_sw_c2 got done/err=%b want 10",
                     {bus.done, bus.err});
        end
        step();
    endtask

    initial begin
        n_checks  = 0;
        n_fail    = 0;
        wr_cnt    = 0;
        last_wa   = '0;
        last_wd   = '0;
        reset     = 1'b1;
        bus.start = 1'b0;
        bus.op    = OP_SW;
        bus.addr  = '0;
        bus.wdata = '0;
        for (int i = 0; i < 64; i++) mem[i] = '0;
        test_reset();
        test_sw();
        test_sb();
        test_sh();
        test_misaligned();
        test_start_busy();
        test_reset_wait();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/store_rmw_unit.md
# store_rmw_unit

Multicycle store path of the datapath: takes a store request (sw, sh, sb) from the control unit and performs the memory write. Sub-word stores are done as a read-modify-write on the containing word. It is the write-side counterpart of the register writeback selection, which receives loaded and computed data. It sits between the control FSM / register B and the 32-bit word memory, and owns the memory address, write-enable and write-data lines while busy.

## Interface
- No parameters. Data/address width is fixed at 32; op encodings come from the shared package.
- clk  input  1  system clock, all state updates on rising edge
- reset  input  1  synchronous, active-high; returns the block to IDLE
- start  input  1  request strobe, sampled only in IDLE
- op  input  2  store type: 00 sw, 01 sh, 10 sb, 11 reserved (treated as misaligned/error)
- addr  input  32  byte address of the store
- wdata  input  32  register B value; sh uses [15:0], sb uses [7:0]
- mem_dout  input  32  memory read data, valid the cycle after mem_addr is presented with mem_wr=0
- mem_addr  output  32  word-aligned memory address ({addr[31:2],2'b00})
- mem_wr  output  1  memory write enable
- mem_din  output  32  memory write data
- busy  output  1  high in every state except IDLE
- done  output  1  one-cycle completion pulse
- err  output  1  one-cycle pulse, coincident with done, for a misaligned or reserved request

## Operation
- States: IDLE, READ, WAIT, WRITE, DONE, ERR.
- IDLE with start=1:
  - op, addr and wdata are latched.
  - Misaligned request goes to ERR. Misaligned means sw with addr[1:0]≠0, sh with addr[0]≠0, or op=11.
  - sw goes to WRITE.
  - sh and sb go to READ.
- READ: mem_addr = aligned address, mem_wr=0. Next state is WAIT.
- WAIT: mem_dout is captured into the word register at the end of this cycle. Next state is WRITE.
- WRITE: mem_wr=1, mem_addr = aligned address, mem_din as follows:
  - sw: the latched wdata.
  - sh: the captured word with the half at addr[1] replaced by wdata[15:0]. addr[1]=0 → bits 15:0; addr[1]=1 → bits 31:16.
  - sb: the captured word with the byte at addr[1:0] replaced by wdata[7:0]. Little-endian: byte k occupies bits 8k+7:8k.
  - Next state is DONE.
- DONE: done=1. Next state is IDLE.
- ERR: done=1 and err=1, mem_wr stays 0, memory is not touched. Next state is IDLE.
- start outside IDLE is ignored. It is neither queued nor does it update the latched request.
- Reset, including mid-operation: all state cleared, next state IDLE. A WRITE cycle interrupted by reset still issues its write only if mem_wr was already high in that cycle. No further write is issued.
- Reset values: mem_addr=0, mem_wr=0, mem_din=0, busy=0, done=0, err=0, latched op/addr/wdata/word = 0.
- All outputs are registered or decoded from registered state only. None of them is combinational from start/op/addr.

## Timing
- Cycle 0 is the edge that samples start=1 in IDLE.
- sw: WRITE in cycle 1, done in cycle 2. start-to-done latency is 2 cycles.
- sh/sb: READ in cycle 1, WAIT in cycle 2, WRITE in cycle 3, done in cycle 4. Latency is 4 cycles.
- Error: done+err in cycle 1. Latency is 1 cycle.
- Back-to-back: start may be reasserted in the cycle done is high. It is sampled in the following IDLE cycle, so the minimum spacing between the two start samples is latency+1.
- mem_wr is high for exactly one cycle per successful store and never high in any other state.
- Memory read latency is exactly 1 cycle. mem_dout is ignored outside WAIT.

## Structure
- Shared package holds:
  - op encodings: OP_SW, OP_SH, OP_SB, OP_RSV.
  - the state enumeration.
  - the misalignment function, so the control unit can reuse it for exception raising.
- One combinational sub-module, store_merge (inputs old_word, wdata, op, addr[1:0] → merged_word), instantiated once. The FSM, latches and output registers stay in the top module.

## Test plan
- sw: addr=0x0000_0010, wdata=0xDEAD_BEEF → mem_wr pulses in cycle 1 with mem_addr=0x10, mem_din=0xDEAD_BEEF; done in cycle 2; err=0.
- sb: memory word at 0x20 = 0x1122_3344, addr=0x22, wdata=0xFFFF_FFAB → read at 0x20, write 0x11AB_3344 in cycle 3, done in cycle 4.
- sh: memory word at 0x30 = 0xAAAA_BBBB, addr=0x32, wdata=0x0000_1234 → write 0x1234_BBBB; repeat with addr=0x30 → write 0xAAAA_1234.
- Misaligned: sh at addr=0x41 and sw at addr=0x42 → done=err=1 in cycle 1, mem_wr never asserted; op=11 behaves identically.
- Start while busy: start held high through an sb to 0x50, addr changed to 0x60 mid-operation → single write to 0x50 only; second request sampled in the IDLE cycle after done.
- Reset in WAIT during sh: no write issued, all outputs 0 the cycle after reset, next sw completes normally with 2-cycle latency.
